// File: rtl/even_parity_serial_rx.sv
// Oversampling serial receiver: start bit, DATA_W data bits (LSB first), even parity, stop bit.
// Delivers each word plus parity/framing flags on a valid/ready port; a word arriving while the port is full is dropped.
module even_parity_serial_rx #(
    parameter int OVS    = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              rxd,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    logic              r_sync1;
    logic              r_sync2;
    logic              w_rxd_s;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [TW-1:0]     r_tick;
    logic [TW-1:0]     w_tick_nxt;
    logic [BW-1:0]     r_bit;
    logic [BW-1:0]     w_bit_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_p_err;
    logic              w_p_err_nxt;
    logic              r_f_err;
    logic              w_f_err_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_overrun;
    logic              r_busy;

    assign w_rxd_s    = r_sync2;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state logic: all counting and sampling happens only on tick cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_p_err_nxt = r_p_err;
        w_f_err_nxt = r_f_err;
        w_done_nxt  = 1'b0;
        if (sample_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rxd_s) begin
                        w_state_nxt = START;
                        w_tick_nxt  = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                START: begin
                    if (r_tick == TICK_HALF) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = w_rxd_s ? IDLE : DATA;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
                DATA: begin
                    if (r_tick == TICK_FULL) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {w_rxd_s, r_shift[DATA_W-1:1]};
                        if (r_bit == BIT_LAST) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = PARITY;
                        end else begin
                            w_bit_nxt = r_bit + BW'(1);
                        end
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
                PARITY: begin
                    if (r_tick == TICK_FULL) begin
                        w_tick_nxt  = '0;
                        w_p_err_nxt = w_rxd_s ^ parity_of(r_shift);
                        w_state_nxt = STOP;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
                STOP: begin
                    if (r_tick == TICK_FULL) begin
                        w_tick_nxt  = '0;
                        w_f_err_nxt = ~w_rxd_s;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = w_rxd_s ? IDLE : WAIT_HIGH;
                    end else begin
                        w_tick_nxt = r_tick + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (w_rxd_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_HIGH;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM state, counters and frame-assembly registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_p_err <= 1'b0;
            r_f_err <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_p_err <= w_p_err_nxt;
            r_f_err <= w_f_err_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Output port: a completion loads only if the slot is empty or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_dout_valid || dout_ready) begin
                    r_dout       <= r_shift;
                    r_parity_err <= r_p_err;
                    r_frame_err  <= r_f_err;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= r_dout_valid;
            end
        end
    end

endmodule

// File: tb/tb_even_parity_serial_rx.sv
// Directed bench for even_parity_serial_rx: frames are driven bit by bit and results checked against hand-computed values.
module tb_even_parity_serial_rx;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       dout_ready = 1'b1;
    logic       slow_tick = 1'b0;
    logic [1:0] tcnt = 2'b00;
    logic       sample_tick;
    logic [7:0] dout;
    logic       dout_valid, parity_err, frame_err, overrun, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int acc_cnt = 0;
    int vcycles = 0;
    int ovr_cnt = 0;
    int rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] acc_data = 8'h00;
    logic acc_perr = 1'b0;
    logic acc_ferr = 1'b0;

    even_parity_serial_rx #(.OVS(OVS), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rxd(rxd),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    assign sample_tick = slow_tick ? (tcnt == 2'b00) : 1'b1;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tcnt <= tcnt + 2'd1;
    end

    always @(negedge clk) begin
        if (dout_valid && dout_ready) begin
            acc_cnt  = acc_cnt + 1;
            acc_data = dout;
            acc_perr = parity_err;
            acc_ferr = frame_err;
        end
        if (dout_valid) vcycles = vcycles + 1;
        if (dout_valid && !prev_valid) rise_cyc = cyc;
        if (overrun) ovr_cnt = ovr_cnt + 1;
        prev_valid = dout_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int mult);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 11; i++) begin
            rxd = f[i];
            idle(OVS * mult);
        end
        rxd = 1'b1;
    endtask

    task automatic check_word(input string name, input int acc0, input logic [7:0] d, input logic pe, input logic fe);
        checks++;
        if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL %s count got %0d want 1", name, acc_cnt - acc0); end
        checks++;
        if ({acc_data, acc_perr, acc_ferr} !== {d, pe, fe})
        begin errors++; $display("FAIL %s word got %h p%b f%b want %h p%b f%b", name, acc_data, acc_perr, acc_ferr, d, pe, fe); end
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; dout_ready = 1'b1;
        idle(3);
        checks++;
        if ({dout, dout_valid, parity_err, frame_err, overrun, busy} !== 13'd0)
        begin errors++; $display("FAIL reset outputs got %h/%b%b%b%b%b want 0", dout, dout_valid, parity_err, frame_err, overrun, busy); end
        rst = 1'b0;
        idle(5);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
    endtask

    task automatic test_good_frame();
        int a0, v0;
        a0 = acc_cnt; v0 = vcycles;
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        idle(10);
        check_word("good_A5", a0, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (vcycles - v0 !== 1) begin errors++; $display("FAIL good_valid_len got %0d want 1", vcycles - v0); end
        checks++;
        if ((rise_cyc - start_cyc) < 168 || (rise_cyc - start_cyc) > 180)
        begin errors++; $display("FAIL good_latency got %0d want 168..180", rise_cyc - start_cyc); end
    endtask

    task automatic test_parity();
        int a0;
        a0 = acc_cnt;
        send_frame(8'h07, 1'b0, 1'b1, 1);
        idle(10);
        check_word("bad_parity", a0, 8'h07, 1'b1, 1'b0);
        a0 = acc_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1);
        idle(10);
        check_word("ok_parity", a0, 8'h07, 1'b0, 1'b0);
    endtask

    task automatic test_break();
        int a0;
        a0 = acc_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1);
        rxd = 1'b0;
        idle(100);
        check_word("break_3C", a0, 8'h3C, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b want 1", busy); end
        rxd = 1'b1;
        idle(10);
        checks++;
        if (busy !== 1'b0 || acc_cnt - a0 !== 1)
        begin errors++; $display("FAIL break_release busy %b count %0d want 0 1", busy, acc_cnt - a0); end
        a0 = acc_cnt;
        send_frame(8'h55, 1'b0, 1'b1, 1);
        idle(10);
        check_word("after_break_55", a0, 8'h55, 1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        int a0, v0;
        a0 = acc_cnt; v0 = vcycles;
        rxd = 1'b0;
        idle(4);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_on got %b want 1", busy); end
        rxd = 1'b1;
        idle(30);
        checks++;
        if (busy !== 1'b0 || acc_cnt != a0 || vcycles != v0 || parity_err !== 1'b0 || frame_err !== 1'b0)
        begin errors++; $display("FAIL glitch busy %b acc %0d valid %0d pe %b fe %b want 0 0 0 0 0", busy, acc_cnt - a0, vcycles - v0, parity_err, frame_err); end
    endtask

    task automatic test_back_to_back();
        int a0, o0;
        dout_ready = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, 1);
        send_frame(8'h22, 1'b0, 1'b1, 1);
        idle(10);
        checks++;
        if (dout !== 8'h11 || dout_valid !== 1'b1) begin errors++; $display("FAIL overrun_hold dout %h valid %b want 11 1", dout, dout_valid); end
        checks++;
        if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_pulse got %0d cycles want 1", ovr_cnt - o0); end
        dout_ready = 1'b1;
        idle(5);
        check_word("drain_11", a0, 8'h11, 1'b0, 1'b0);
        checks++;
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL drain_clear valid got %b want 0", dout_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int a0;
        logic [9:0] f;
        f = {1'b1, 1'b0, 8'hF0};
        rxd = 1'b0;
        idle(OVS);
        for (int i = 0; i < 4; i++) begin
            rxd = f[i];
            idle(OVS);
        end
        rxd = f[4];
        idle(OVS / 2);
        rst = 1'b1;
        idle(1);
        checks++;
        if ({dout, dout_valid, parity_err, frame_err, overrun, busy} !== 13'd0)
        begin errors++; $display("FAIL midreset outputs got %h/%b%b%b%b%b want 0", dout, dout_valid, parity_err, frame_err, overrun, busy); end
        rst = 1'b0;
        rxd = 1'b1;
        idle(30);
        a0 = acc_cnt;
        send_frame(8'h81, 1'b0, 1'b1, 1);
        idle(10);
        check_word("after_reset_81", a0, 8'h81, 1'b0, 1'b0);
    endtask

    task automatic test_slow_tick();
        int a0;
        slow_tick = 1'b1;
        a0 = acc_cnt;
        send_frame(8'h5A, 1'b0, 1'b1, 4);
        idle(20);
        check_word("slow_tick_5A", a0, 8'h5A, 1'b0, 1'b0);
        slow_tick = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_good_frame();
        test_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_slow_tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
